// File: rtl/conv_output_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_output_writer: adds a layer bias to PE-array result rows and writes   |
// | them word by word into the output feature-map RAM in raster order.        |
// | Optional: define RELU_EN to clamp negative results to zero.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module conv_output_writer #(
  parameter int WIDTH       = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int IMAGE_SIZE  = 8,
  parameter int ARRAY_SIZE  = 6,
  parameter int ADDR_WIDTH  = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable_i,
  input  logic                        start_i,
  input  logic [WIDTH-1:0]            bias_i,
  input  logic                        row_valid_i,
  output logic                        row_ready_o,
  input  logic [WIDTH*ARRAY_SIZE-1:0] row_data_i,
  output logic                        ram_we_o,
  output logic [ADDR_WIDTH-1:0]       ram_addr_o,
  output logic [WIDTH-1:0]            ram_wdata_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int CNT_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  generate
    if ((ARRAY_SIZE != IMAGE_SIZE - KERNEL_SIZE + 1) ||
        ((ARRAY_SIZE * ARRAY_SIZE) > (1 << ADDR_WIDTH))) begin : g_cfg_check
      $error("conv_output_writer: inconsistent ARRAY_SIZE / ADDR_WIDTH");
    end
  endgenerate

  logic [1:0]                  state_q, state_d;
  logic [CNT_W-1:0]            row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0]            col_cnt_q, col_cnt_d;
  logic [WIDTH*ARRAY_SIZE-1:0] row_q, row_d;
  logic [WIDTH-1:0]            bias_q, bias_d;

  logic                  w_last_col;
  logic                  w_last_row;
  logic                  w_in_write;
  logic [WIDTH-1:0]      w_word;
  logic [WIDTH-1:0]      w_sum;
  logic [WIDTH-1:0]      w_result;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_last_col = (col_cnt_q == CNT_W'(ARRAY_SIZE - 1));
  assign w_last_row = (row_cnt_q == CNT_W'(ARRAY_SIZE - 1));

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    row_d     = row_q;
    bias_d    = bias_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_LOAD;
          bias_d    = bias_i;
          row_cnt_d = '0;
          col_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (row_valid_i) begin
          row_d     = row_data_i;
          col_cnt_d = '0;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_last_col) begin
          col_cnt_d = '0;
          if (w_last_row) begin
            state_d = S_DONE;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
            state_d   = S_LOAD;
          end
        end else begin
          col_cnt_d = col_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        // Clearing here lets a back-to-back run restart at address 0.
        row_cnt_d = '0;
        col_cnt_d = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      row_q     <= '0;
      bias_q    <= '0;
    end else if (enable_i) begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
      row_q     <= row_d;
      bias_q    <= bias_d;
    end
  end

  assign w_in_write = (state_q == S_WRITE);
  assign w_word     = row_q[col_cnt_q*WIDTH +: WIDTH];
  assign w_sum      = w_word + bias_q;
  assign w_addr     = (ADDR_WIDTH'(row_cnt_q) * ADDR_WIDTH'(ARRAY_SIZE)) + ADDR_WIDTH'(col_cnt_q);

`ifdef RELU_EN
  assign w_result = w_sum[WIDTH-1] ? '0 : w_sum;
`else
  assign w_result = w_sum;
`endif

  // Address/data are zeroed outside WRITE so idle outputs read as all zero.
  assign ram_we_o    = w_in_write & enable_i;
  assign ram_addr_o  = w_in_write ? w_addr : '0;
  assign ram_wdata_o = w_in_write ? w_result : '0;
  assign row_ready_o = (state_q == S_LOAD);
  assign busy_o      = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign done_o      = (state_q == S_DONE);

endmodule
`default_nettype wire
